// File: rtl/serial_pattern_generator_pkg.sv
// Shared constants and FSM state encoding for the serial pattern generator.
// DEFAULT_PATTERN is also the reference pattern used by the detector benches.
package serial_pattern_generator_pkg;

  localparam int unsigned DEF_PAT_W = 6;
  localparam int unsigned DEF_CNT_W = 4;
  localparam int unsigned DEF_GAP_W = 3;

  localparam logic [DEF_PAT_W-1:0] DEFAULT_PATTERN = 6'b110110;

  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

endpackage

// File: rtl/serial_pattern_generator_if.sv
// Control/data bundle between a pattern generator and whatever drives it.
interface serial_pattern_generator_if
  import serial_pattern_generator_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned GAP_W = DEF_GAP_W
);
  logic             start;
  logic             abort;
  logic             load_pattern;
  logic [PAT_W-1:0] pattern_in;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, load_pattern, pattern_in, repeat_cnt, gap_len,
    input  dout, dout_valid, frame_start, busy, done
  );

  modport slave (
    input  start, abort, load_pattern, pattern_in, repeat_cnt, gap_len,
    output dout, dout_valid, frame_start, busy, done
  );
endinterface

// File: rtl/pattern_shifter.sv
// MSB-first parallel-load shift register; zero fill so it drains to 0
// after a full frame, which keeps the serial output low between frames.
module pattern_shifter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pin,
  output logic         sout
);
  logic [W-1:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (load)  q <= pin;
    else if (shift) q <= {q[W-2:0], 1'b0};
  end

  assign sout = q[W-1];
endmodule

// File: rtl/serial_pattern_generator.sv
// Serial pattern transmitter: N repetitions of a programmable pattern,
// MSB first, with an optional idle gap between repetitions.
module serial_pattern_generator
  import serial_pattern_generator_pkg::*;
#(
  parameter int unsigned      PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int unsigned      CNT_W   = DEF_CNT_W,
  parameter int unsigned      GAP_W   = DEF_GAP_W
) (
  input logic clk,
  input logic reset,
  serial_pattern_generator_if.slave bus
);
  localparam int unsigned      BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(PAT_W - 1);

  state_t           state, state_d;
  logic [BIT_W-1:0] bit_idx, bit_d;
  logic [CNT_W-1:0] rep_left, rep_d;
  logic [GAP_W-1:0] gap_lat, gap_lat_d;
  logic [GAP_W-1:0] gap_cnt, gap_d;
  logic [PAT_W-1:0] pat_reg, pat_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sh_load, sh_shift, sh_out;
  logic [PAT_W-1:0] sh_pin;

  pattern_shifter #(.W(PAT_W)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .pin   (sh_pin),
    .sout  (sh_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx  <= '0;
      rep_left <= '0;
      gap_lat  <= '0;
      gap_cnt  <= '0;
      pat_reg  <= PATTERN;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      bit_idx  <= bit_d;
      rep_left <= rep_d;
      gap_lat  <= gap_lat_d;
      gap_cnt  <= gap_d;
      pat_reg  <= pat_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; every frame begins with a shifter load.
  always_comb begin
    state_d   = state;
    bit_d     = bit_idx;
    rep_d     = rep_left;
    gap_lat_d = gap_lat;
    gap_d     = gap_cnt;
    pat_d     = pat_reg;
    valid_d   = 1'b0;
    fs_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_pin    = pat_reg;
    case (state)
      IDLE: begin
        if (bus.load_pattern) pat_d = bus.pattern_in;
        if (bus.start && !bus.abort) begin
          gap_lat_d = bus.gap_len;
          rep_d     = bus.repeat_cnt;
          if (bus.repeat_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SEND;
            bit_d   = LAST_IDX;
            sh_load = 1'b1;
            sh_pin  = bus.load_pattern ? bus.pattern_in : pat_reg;
            valid_d = 1'b1;
            fs_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
          sh_load = 1'b1;
          sh_pin  = '0;
        end else if (bit_idx != '0) begin
          bit_d    = bit_idx - BIT_W'(1);
          sh_shift = 1'b1;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end else if (rep_left == CNT_W'(1)) begin
          state_d  = IDLE;
          rep_d    = '0;
          sh_shift = 1'b1;
          done_d   = 1'b1;
        end else begin
          rep_d = rep_left - CNT_W'(1);
          if (gap_lat == '0) begin
            bit_d   = LAST_IDX;
            sh_load = 1'b1;
            valid_d = 1'b1;
            fs_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d  = GAP;
            gap_d    = gap_lat;
            sh_shift = 1'b1;
            busy_d   = 1'b1;
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_d = SEND;
          bit_d   = LAST_IDX;
          sh_load = 1'b1;
          valid_d = 1'b1;
          fs_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gap_d  = gap_cnt - GAP_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout        = sh_out;
  assign bus.dout_valid  = valid_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench for serial_pattern_generator: directed scenarios with literal
// waveforms plus randomized traffic against a queue-based frame model.
module tb_serial_pattern_generator;
  import serial_pattern_generator_pkg::*;

  localparam int unsigned PW = 6;
  localparam int unsigned CW = 4;
  localparam int unsigned GW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_pattern_generator_if #(.PAT_W(PW), .CNT_W(CW), .GAP_W(GW)) bus ();

  serial_pattern_generator #(
    .PAT_W(PW), .PATTERN(6'b110110), .CNT_W(CW), .GAP_W(GW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic dout;
    logic valid;
    logic fs;
    logic busy;
    logic done;
  } obs_t;

  obs_t          cur = '0;
  obs_t          q[$];
  logic [PW-1:0] mpat = 6'b110110;
  int            checks = 0;
  int            errors = 0;

  function automatic obs_t dut_obs();
    dut_obs = {bus.dout, bus.dout_valid, bus.frame_start, bus.busy, bus.done};
  endfunction

  // Expected per-cycle outputs of a whole transmission, ending with done.
  function automatic void build(input logic [PW-1:0] sp, input int n, input int g);
    for (int r = 0; r < n; r++) begin
      for (int b = 0; b < int'(PW); b++)
        q.push_back({sp[PW-1-b], 1'b1, (b == 0), 1'b1, 1'b0});
      if (r < n - 1)
        for (int k = 0; k < g; k++) q.push_back(5'b00010);
    end
    q.push_back(5'b00001);
  endfunction

  always @(posedge clk) begin
    logic [PW-1:0] sp;
    if (reset) begin
      q.delete();
      cur  = '0;
      mpat = 6'b110110;
    end else begin
      if (!cur.busy) begin
        sp = bus.load_pattern ? bus.pattern_in : mpat;
        if (bus.load_pattern) mpat = bus.pattern_in;
        if (bus.start && !bus.abort) build(sp, int'(bus.repeat_cnt), int'(bus.gap_len));
      end else if (bus.abort) begin
        q.delete();
      end
      if (q.size() > 0) cur = q.pop_front();
      else              cur = '0;
    end
    #1;
    checks++;
    if (dut_obs() !== cur) begin
      errors++;
      $display("FAIL cycle_model t=%0t got {dout,valid,fs,busy,done}=%b want %b",
               $time, dut_obs(), cur);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic kick(input logic [CW-1:0] n, input logic [GW-1:0] g,
                      input logic st, input logic ab);
    @(negedge clk);
    bus.start      = st;
    bus.abort      = ab;
    bus.repeat_cnt = n;
    bus.gap_len    = g;
  endtask

  // Samples outputs for n cycles; optionally injects an ignored load+start or an abort.
  task automatic capture(input int n, input int load_at, input int abort_at,
                         output logic [63:0] d, output logic [63:0] v,
                         output logic [63:0] f, output logic [63:0] b,
                         output logic [63:0] dn);
    d = '0; v = '0; f = '0; b = '0; dn = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      d  = {d[62:0],  bus.dout};
      v  = {v[62:0],  bus.dout_valid};
      f  = {f[62:0],  bus.frame_start};
      b  = {b[62:0],  bus.busy};
      dn = {dn[62:0], bus.done};
      if (i == 0) begin
        bus.start = 1'b0; bus.load_pattern = 1'b0; bus.abort = 1'b0;
      end
      if (i == load_at) begin
        bus.load_pattern = 1'b1; bus.pattern_in = 6'b111111;
        bus.start = 1'b1; bus.repeat_cnt = 4'd5;
      end
      if (i == load_at + 1) begin
        bus.load_pattern = 1'b0; bus.start = 1'b0;
      end
      if (i == abort_at)     bus.abort = 1'b1;
      if (i == abort_at + 1) bus.abort = 1'b0;
    end
    bus.start = 1'b0; bus.load_pattern = 1'b0; bus.abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] d, v, f, b, dn;
    bus.start = 1'b0; bus.abort = 1'b0; bus.load_pattern = 1'b0;
    bus.pattern_in = '0; bus.repeat_cnt = '0; bus.gap_len = '0;
    #10 reset = 1'b0;
    @(posedge clk); #2;
    chk("reset_idle", 64'(dut_obs()), 64'(0));

    kick(4'd1, 3'd0, 1'b1, 1'b0);
    capture(8, -1, -1, d, v, f, b, dn);
    chk("single_dout", d, 64'(8'b11011000));
    chk("single_valid", v, 64'(8'b11111100));
    chk("single_fs", f, 64'(8'b10000000));
    chk("single_busy", b, 64'(8'b11111100));
    chk("single_done", dn, 64'(8'b00000010));

    kick(4'd3, 3'd0, 1'b1, 1'b0);
    capture(20, -1, -1, d, v, f, b, dn);
    chk("b2b_dout", d, 64'(20'b11011011011011011000));
    chk("b2b_fs", f, 64'(20'b10000010000010000000));
    chk("b2b_busy", b, 64'(20'b11111111111111111100));
    chk("b2b_done", dn, 64'(20'b00000000000000000010));

    kick(4'd2, 3'd3, 1'b1, 1'b0);
    capture(17, -1, -1, d, v, f, b, dn);
    chk("gap_dout", d, 64'(17'b11011000011011000));
    chk("gap_valid", v, 64'(17'b11111100011111100));
    chk("gap_busy", b, 64'(17'b11111111111111100));
    chk("gap_done", dn, 64'(17'b00000000000000010));

    kick(4'd0, 3'd2, 1'b1, 1'b0);
    capture(3, -1, -1, d, v, f, b, dn);
    chk("rep0_done", dn, 64'(3'b100));
    chk("rep0_valid", v, 64'(3'b000));

    kick(4'd2, 3'd0, 1'b1, 1'b1);
    capture(4, -1, -1, d, v, f, b, dn);
    chk("start_abort_busy", b, 64'(0));
    chk("start_abort_valid", v, 64'(0));

    kick(4'd2, 3'd0, 1'b1, 1'b0);
    capture(8, -1, 2, d, v, f, b, dn);
    chk("abort_dout", d, 64'(8'b11000000));
    chk("abort_busy", b, 64'(8'b11100000));
    chk("abort_done", dn, 64'(0));

    @(negedge clk); bus.load_pattern = 1'b1; bus.pattern_in = 6'b101001;
    @(negedge clk); bus.load_pattern = 1'b0;
    kick(4'd1, 3'd0, 1'b1, 1'b0);
    capture(8, -1, -1, d, v, f, b, dn);
    chk("load_dout", d, 64'(8'b10100100));

    kick(4'd2, 3'd0, 1'b1, 1'b0);
    capture(14, 3, -1, d, v, f, b, dn);
    chk("midload_dout", d, 64'(14'b10100110100100));
    chk("midload_fs", f, 64'(14'b10000010000000));
    chk("midload_done", dn, 64'(14'b00000000000010));
    kick(4'd1, 3'd0, 1'b1, 1'b0);
    capture(8, -1, -1, d, v, f, b, dn);
    chk("after_midload_dout", d, 64'(8'b10100100));

    kick(4'd2, 3'd0, 1'b1, 1'b0);
    capture(3, -1, -1, d, v, f, b, dn);
    reset = 1'b1;
    #1;
    chk("async_reset", 64'(dut_obs()), 64'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    kick(4'd1, 3'd0, 1'b1, 1'b0);
    capture(8, -1, -1, d, v, f, b, dn);
    chk("reset_pattern_dout", d, 64'(8'b11011000));

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.start        = ($urandom_range(0, 5) == 0);
      bus.abort        = ($urandom_range(0, 49) == 0);
      bus.load_pattern = ($urandom_range(0, 9) == 0);
      bus.pattern_in   = PW'($urandom());
      bus.repeat_cnt   = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 15))
                                                     : CW'($urandom_range(0, 3));
      bus.gap_len      = GW'($urandom_range(0, 7));
      reset            = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0; bus.load_pattern = 1'b0; reset = 1'b0;
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_pattern_generator.md
Name: serial_pattern_generator

Overview:
- Serial bit-pattern transmitter that drives a single-bit stream, one bit per clock, MSB first.
- Default pattern is 6'b110110, programmable at runtime.
- It is the stimulus/transmit end for the team's serial sequence detectors. It feeds their din input in loopback benches and on-chip self-test.
- Supports a repeat count and an inter-pattern gap, so overlapping and non-overlapping detection can both be exercised.

Parameters:
- PAT_W, 6, pattern length in bits.
- PATTERN, 6'b110110, reset value of the pattern register.
- CNT_W, 4, width of the repeat count.
- GAP_W, 3, width of the inter-pattern gap length.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a transmission; sampled only in IDLE
- abort  input  1  terminate a transmission immediately
- load_pattern  input  1  load pattern_in into the pattern register; honoured only in IDLE
- pattern_in  input  PAT_W  new pattern value
- repeat_cnt  input  CNT_W  number of pattern repetitions; latched at start
- gap_len  input  GAP_W  idle cycles between repetitions; latched at start
- dout  output  1  serial data, MSB first
- dout_valid  output  1  dout carries a pattern bit
- frame_start  output  1  one-cycle pulse on the first bit of each repetition
- busy  output  1  transmission in progress
- done  output  1  one-cycle pulse when the final bit has been sent

Behaviour:
- Reset (asynchronous, any time, including mid-transmission):
  - State goes to IDLE; pattern register goes to PATTERN; counters clear.
  - dout, dout_valid, frame_start, busy and done all go to 0.
- All outputs are registered.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - dout=0, dout_valid=0, busy=0.
  - load_pattern=1 writes pattern_in into the pattern register.
  - On start=1:
    - Latch repeat_cnt and gap_len.
    - If repeat_cnt=0: stay in IDLE and pulse done for one cycle; no bits are sent.
    - Otherwise go to SEND. At the same edge drive dout=pat[PAT_W-1], dout_valid=1, frame_start=1, busy=1.
    - Latency is one cycle: the first bit is visible the cycle after start is sampled.
  - load_pattern and start on the same edge: the transmission uses pattern_in.
- SEND:
  - Each edge presents the next lower bit; bit index runs PAT_W-1 down to 0.
  - After bit 0 with repetitions remaining:
    - If gap=0: go straight to the next repetition's MSB, with frame_start=1 (back-to-back stream).
    - If gap>0: go to GAP.
  - After bit 0 of the last repetition:
    - Go to IDLE, with done=1 for one cycle, busy=0, dout_valid=0, dout=0.
- GAP:
  - dout=0, dout_valid=0, busy=1.
  - Count down exactly gap cycles, then return to SEND with the MSB and frame_start=1.
- Total busy cycles = N*PAT_W + (N-1)*G, where N is the latched repeat count and G the latched gap.
- start and load_pattern are ignored while busy=1. Latched values are unaffected by input changes mid-transmission.
- abort=1 in SEND or GAP:
  - Go to IDLE at the next edge; dout, dout_valid, frame_start and busy all go to 0.
  - done is NOT asserted.
- abort has priority over start when both are high in IDLE; the block stays idle.
- Start coinciding with the done cycle: the state is already IDLE, so start is accepted and the new first bit appears the following cycle.
- frame_start is only ever high when dout_valid is high.

Decomposition:
- Shared package (e.g. pattern_gen_pkg):
  - FSM state enum {IDLE, SEND, GAP}.
  - Default pattern constant 6'b110110, reused by the detector benches.
- One natural sub-module: pattern_shifter.
  - Parallel-load, MSB-first PISO shift register of width PAT_W.
  - Ports: load, shift, parallel-in, serial-out.
- The FSM and counters stay in the top module.

Test Plan:
- Reset idle check: reset=1 for 10 ns, then release → dout=0, dout_valid=0, busy=0, done=0. Assert reset mid-SEND → all outputs 0 immediately, with no clock edge needed.
- Single frame: start with repeat_cnt=1, gap_len=0 → dout=1,1,0,1,1,0 on 6 consecutive cycles, dout_valid=1 throughout, frame_start only on the first bit; done=1 and busy=0 on cycle 7.
- Back-to-back: repeat_cnt=3, gap_len=0 → 18-bit stream 110110110110110110; frame_start on cycles 1, 7 and 13; done on cycle 19.
- Gapped: repeat_cnt=2, gap_len=3 → 110110, then 3 cycles with dout_valid=0 and dout=0, then 110110; busy high for 15 cycles; done on cycle 16.
- Pattern load:
  - load_pattern=1 with pattern_in=6'b101001 in IDLE, then start with repeat_cnt=1 → 1,0,1,0,0,1.
  - A load_pattern pulse mid-transmission has no effect on the current or next frame.
  - repeat_cnt=0 → done pulse one cycle after start, with dout_valid never asserted.
- Abort: repeat_cnt=2, abort asserted while the 3rd bit is on dout → next cycle dout_valid=0 and busy=0, and done stays 0. start and abort high together in IDLE → no transmission.
